// File: rtl/tblock_distributor_pkg.sv
// bgpu_dispatch_pkg: request field types and the distributor FSM state encoding.
// Latency: not applicable, this file holds only types and constants.
// Backpressure: not applicable.
package bgpu_dispatch_pkg;

  localparam int PcWidth        = 16;
  localparam int AddressWidth   = 32;
  localparam int TblockIdxBits  = 5;
  localparam int TgroupIdBits   = 8;
  localparam int TblockSizeBits = 6;

  typedef logic [PcWidth-1:0]        pc_t;
  typedef logic [AddressWidth-1:0]   addr_t;
  typedef logic [TblockIdxBits-1:0]  tblock_idx_t;
  typedef logic [TblockSizeBits-1:0] tblock_size_t;
  typedef logic [TgroupIdBits-1:0]   tgroup_id_t;

  // Field order is relied on when requests are packed or unpacked as a flat vector
  typedef struct packed {
    pc_t          pc;
    addr_t        dp_addr;
    tblock_size_t tblock_size;
    tblock_idx_t  tblock_idx;
    tgroup_id_t   tgroup_id;
  } warp_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_OFFER = 2'd2
  } dist_state_e;

endpackage

// File: rtl/tblock_distributor_if.sv
// tblock_distributor_if: upstream allocate stream plus the cluster offer/done signals.
// Latency: not applicable, wiring only.
// Backpressure: warp_free_o gates the upstream side, cu_ready_i gates each cluster offer.
interface tblock_distributor_if
  import bgpu_dispatch_pkg::*;
#(
  parameter int NumClusters = 4
) ();

  // Upstream request stream
  logic         allocate_warp_i;
  logic         warp_free_o;
  pc_t          allocate_pc_i;
  addr_t        dp_addr_i;
  tblock_size_t tblock_size_i;
  tblock_idx_t  tblock_idx_i;
  tgroup_id_t   tgroup_id_i;

  // Cluster side: one-hot offer, broadcast data, per-cluster ready and done
  logic [NumClusters-1:0] cu_valid_o;
  logic [NumClusters-1:0] cu_ready_i;
  logic [NumClusters-1:0] cu_done_i;
  pc_t                    cu_pc_o;
  addr_t                  cu_dp_addr_o;
  tblock_size_t           cu_tblock_size_o;
  tblock_idx_t            cu_tblock_idx_o;
  tgroup_id_t             cu_tgroup_id_o;

  // Distributor view
  modport slave (
    input  allocate_warp_i, allocate_pc_i, dp_addr_i, tblock_size_i, tblock_idx_i, tgroup_id_i,
    input  cu_ready_i, cu_done_i,
    output warp_free_o, cu_valid_o,
    output cu_pc_o, cu_dp_addr_o, cu_tblock_size_o, cu_tblock_idx_o, cu_tgroup_id_o
  );

  // Dispatcher and cluster view
  modport master (
    output allocate_warp_i, allocate_pc_i, dp_addr_i, tblock_size_i, tblock_idx_i, tgroup_id_i,
    output cu_ready_i, cu_done_i,
    input  warp_free_o, cu_valid_o,
    input  cu_pc_o, cu_dp_addr_o, cu_tblock_size_o, cu_tblock_idx_o, cu_tgroup_id_o
  );

endinterface

// File: rtl/tblock_distributor_credit.sv
// warp_credit_counter: free warp slots of one cluster, +1 on done, -1 on dispatch, saturating.
// Latency: count updates on the clock edge after inc/dec.
// Backpressure: none; has_credit is what gates dispatch to this cluster.
module warp_credit_counter
  import bgpu_dispatch_pkg::*;
#(
  parameter  int Credits = 8,
  localparam int CntW    = $clog2(Credits + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] count,
  output logic            has_credit
);

  localparam logic [CntW-1:0] Full = CntW'(Credits);

  logic [CntW-1:0] count_q;

  // Simultaneous inc and dec cancel; a done at full and a dispatch at zero are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Full;
    end else if (inc && !dec && (count_q != Full)) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count      = count_q;
  assign has_credit = (count_q != '0);

`ifndef SYNTHESIS
  // A completion with every slot already free means a cluster returned more than it took
  done_at_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inc && !dec && (count_q == Full)))
    else $warning("warp_credit_counter: done pulse at full credit count ignored");
`endif

endmodule

// File: rtl/tblock_distributor.sv
// tblock_distributor: forwards one warp request at a time to a cluster with free credits, round-robin.
// Latency: cu_valid_o rises 2 cycles after upstream accept; one warp per 3 cycles at best.
// Backpressure: warp_free_o low while a request is held; waits in ARB without credits, in OFFER until target ready.
// Optional feature: define TBLOCK_DISTRIBUTOR_STATS_EN to build per-cluster 32-bit dispatch counters.
module tblock_distributor
  import bgpu_dispatch_pkg::*;
#(
  parameter  int NumClusters       = 4,
  parameter  int CreditsPerCluster = 8,
  localparam int CntW              = $clog2(CreditsPerCluster + 1),
  localparam int IdxW              = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  tblock_distributor_if.slave         bus,
  output logic [NumClusters*CntW-1:0] credits_o,
  output logic                        idle_o,
  output logic [NumClusters*32-1:0]   stats_dispatched_o
);

  dist_state_e            state_q;
  warp_req_t              req_q;
  logic                   warp_free_q;
  logic [NumClusters-1:0] cu_valid_q;
  logic [IdxW-1:0]        target_q;
  logic [IdxW-1:0]        rr_q;

  logic [NumClusters-1:0] has_credit;
  logic [NumClusters-1:0] full;
  logic [NumClusters-1:0] dec;
  logic [CntW-1:0]        count [NumClusters];
  logic                   handshake;
  logic                   pick_vld;
  logic [IdxW-1:0]        pick;
  int                     scan_idx;

  assign handshake = (state_q == ST_OFFER) && bus.cu_ready_i[target_q];

  for (genvar c = 0; c < NumClusters; c++) begin : g_cred
    assign dec[c] = handshake && (target_q == IdxW'(c));

    warp_credit_counter #(
      .Credits (CreditsPerCluster)
    ) u_credit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc        (bus.cu_done_i[c]),
      .dec        (dec[c]),
      .count      (count[c]),
      .has_credit (has_credit[c])
    );

    assign full[c]                    = (count[c] == CntW'(CreditsPerCluster));
    assign credits_o[c*CntW +: CntW]  = count[c];
  end

  // First cluster with a free slot, scanning upward from the round-robin pointer with wrap
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int i = 0; i < NumClusters; i++) begin
      scan_idx = (int'(rr_q) + i) % NumClusters;
      if (!pick_vld && has_credit[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx[IdxW-1:0];
      end
    end
  end

  // Request FSM: capture, pick a target, then hold the offer until the target accepts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      warp_free_q <= 1'b1;
      cu_valid_q  <= '0;
      target_q    <= '0;
      rr_q        <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.allocate_warp_i) begin
            req_q.pc          <= bus.allocate_pc_i;
            req_q.dp_addr     <= bus.dp_addr_i;
            req_q.tblock_size <= bus.tblock_size_i;
            req_q.tblock_idx  <= bus.tblock_idx_i;
            req_q.tgroup_id   <= bus.tgroup_id_i;
            warp_free_q       <= 1'b0;
            state_q           <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (pick_vld) begin
            target_q   <= pick;
            cu_valid_q <= NumClusters'(1) << pick;
            state_q    <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (handshake) begin
            cu_valid_q  <= '0;
            warp_free_q <= 1'b1;
            rr_q        <= (target_q == IdxW'(NumClusters - 1)) ? '0 : target_q + 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.warp_free_o      = warp_free_q;
  assign bus.cu_valid_o       = cu_valid_q;
  assign bus.cu_pc_o          = req_q.pc;
  assign bus.cu_dp_addr_o     = req_q.dp_addr;
  assign bus.cu_tblock_size_o = req_q.tblock_size;
  assign bus.cu_tblock_idx_o  = req_q.tblock_idx;
  assign bus.cu_tgroup_id_o   = req_q.tgroup_id;

  assign idle_o = (state_q == ST_IDLE) && (&full);

`ifdef TBLOCK_DISTRIBUTOR_STATS_EN
  for (genvar c = 0; c < NumClusters; c++) begin : g_stats
    logic [31:0] disp_q;

    // Free-running dispatch count for this cluster, wraps at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        disp_q <= '0;
      end else if (dec[c]) begin
        disp_q <= disp_q + 32'd1;
      end
    end

    assign stats_dispatched_o[c*32 +: 32] = disp_q;
  end
`else
  assign stats_dispatched_o = '0;
`endif

endmodule

// File: tb/tb_tblock_distributor.sv
// tb_tblock_distributor: random upstream stream, random cluster ready/done, in-order scoreboard.
// Latency: the monitor predicts offer timing and target from free-slot counts and the rotation point.
// Backpressure: cluster ready is randomised per phase, including long all-low stretches.
module tb_tblock_distributor;
  import bgpu_dispatch_pkg::*;

  localparam int NC = 4;
  localparam int CR = 8;
  localparam int CW = $clog2(CR + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tblock_distributor_if #(.NumClusters(NC)) bus ();
  logic [NC*CW-1:0] credits;
  logic             idle;
  logic [NC*32-1:0] stats;

  tblock_distributor #(
    .NumClusters       (NC),
    .CreditsPerCluster (CR)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .bus                (bus),
    .credits_o          (credits),
    .idle_o             (idle),
    .stats_dispatched_o (stats)
  );

  int        n_checks = 0;
  int        n_passed = 0;
  warp_req_t exp_q[$];
  int        tgt_log[$];
  int        m_out [NC];   // warps outstanding per cluster (slots in use)
  int        m_st  [NC];   // dispatches per cluster since reset
  int        pending [NC]; // dispatched warps whose done pulse is still to come
  int        m_rr;
  bit        m_held;
  int        ready_pct = 100;
  bit        done_en   = 1'b0;
  logic [NC-1:0] inject_done = '0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cluster side: random ready, and one delayed done per dispatched warp
  initial begin : cluster_drv
    logic [NC-1:0] rdy;
    logic [NC-1:0] dn;
    bus.cu_ready_i = '0;
    bus.cu_done_i  = '0;
    for (int c = 0; c < NC; c++) pending[c] = 0;
    forever begin
      tick();
      rdy = '0;
      dn  = '0;
      if (!rst_n) begin
        for (int c = 0; c < NC; c++) pending[c] = 0;
      end else begin
        for (int c = 0; c < NC; c++) begin
          rdy[c] = ($urandom_range(99) < ready_pct);
          if (inject_done[c] || (done_en && pending[c] > 0 && $urandom_range(3) == 0)) begin
            dn[c] = 1'b1;
            if (pending[c] > 0) pending[c]--;
          end
        end
      end
      inject_done    = '0;
      bus.cu_ready_i = rdy;
      bus.cu_done_i  = dn;
    end
  end

  // Monitor and reference model, sampled on the falling edge
  initial begin : monitor
    bit            exp_known, exp_vld, hs, all_free;
    int            exp_tgt, cur_tgt, nxt;
    logic [NC-1:0] vld, oh;
    warp_req_t     got;
    exp_known = 0; exp_vld = 0; exp_tgt = 0; cur_tgt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_held = 0; m_rr = 0; exp_known = 0; cur_tgt = 0;
        for (int c = 0; c < NC; c++) begin m_out[c] = 0; m_st[c] = 0; end
        exp_q.delete();
      end else begin
        vld      = bus.cu_valid_o;
        all_free = 1;
        for (int c = 0; c < NC; c++) begin
          check(credits[c*CW +: CW] == CW'(CR - m_out[c]), "credits", credits[c*CW +: CW], CR - m_out[c]);
          if (m_out[c] != 0) all_free = 0;
        end
        check(idle == (!m_held && all_free), "idle", idle, !m_held && all_free);
        check(bus.warp_free_o == !m_held, "warp_free", bus.warp_free_o, !m_held);
        if (exp_known) begin
          check((vld != 0) == exp_vld, "offer_timing", vld, exp_vld);
          if (exp_vld) cur_tgt = exp_tgt;
        end
        hs = 0;
        if (vld != 0) begin
          oh = '0;
          oh[cur_tgt] = 1'b1;
          check(vld == oh, exp_known ? "offer_target" : "offer_stable", vld, oh);
          got = {bus.cu_pc_o, bus.cu_dp_addr_o, bus.cu_tblock_size_o, bus.cu_tblock_idx_o, bus.cu_tgroup_id_o};
          check(exp_q.size() != 0, "offer_without_request", vld, 0);
          if (exp_q.size() != 0) check(got == exp_q[0], "offer_data", got, exp_q[0]);
          hs = bus.cu_ready_i[cur_tgt];
        end
        // Held with no offer means arbitration this cycle: the offer follows iff some slot is free now
        exp_known = 0;
        if (m_held && vld == 0) begin
          exp_known = 1; exp_vld = 0; exp_tgt = 0;
          for (int k = 0; k < NC; k++) begin
            nxt = (m_rr + k) % NC;
            if (!exp_vld && m_out[nxt] < CR) begin exp_vld = 1; exp_tgt = nxt; end
          end
        end
        if (hs) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_rr = (cur_tgt + 1) % NC;
          m_st[cur_tgt]++;
          pending[cur_tgt]++;
          tgt_log.push_back(cur_tgt);
          m_held = 0;
        end
        for (int c = 0; c < NC; c++) begin
          m_out[c] = m_out[c] + ((hs && cur_tgt == c) ? 1 : 0) - (bus.cu_done_i[c] ? 1 : 0);
          if (m_out[c] < 0) m_out[c] = 0;
        end
        if (bus.allocate_warp_i && bus.warp_free_o) m_held = 1;
      end
    end
  end

  task automatic send(input int gap);
    warp_req_t r;
    int        t;
    r.pc          = pc_t'($urandom);
    r.dp_addr     = addr_t'($urandom);
    r.tblock_size = tblock_size_t'($urandom);
    r.tblock_idx  = tblock_idx_t'($urandom);
    r.tgroup_id   = tgroup_id_t'($urandom);
    bus.allocate_pc_i   = r.pc;
    bus.dp_addr_i       = r.dp_addr;
    bus.tblock_size_i   = r.tblock_size;
    bus.tblock_idx_i    = r.tblock_idx;
    bus.tgroup_id_i     = r.tgroup_id;
    bus.allocate_warp_i = 1'b1;
    t = 0;
    while (!bus.warp_free_o && t < 3000) begin tick(); t++; end
    check(t < 3000, "accept_wait", t, 3000);
    if (t < 3000) exp_q.push_back(r);
    tick();
    bus.allocate_warp_i = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic bit drained(input bit need_done);
    bit d;
    d = (exp_q.size() == 0) && !m_held;
    if (need_done)
      for (int c = 0; c < NC; c++) if (pending[c] != 0 || m_out[c] != 0) d = 0;
    return d;
  endfunction

  task automatic wait_drain(input bit need_done, input string what);
    int t = 0;
    while (!drained(need_done) && t < 5000) begin tick(); t++; end
    check(t < 5000, what, t, 5000);
    repeat (2) tick();
  endtask

  task automatic check_reset_state();
    check(bus.cu_valid_o == '0, "rst_cu_valid", bus.cu_valid_o, 0);
    check(bus.warp_free_o == 1'b1, "rst_warp_free", bus.warp_free_o, 1);
    check(idle == 1'b1, "rst_idle", idle, 1);
    check({bus.cu_pc_o, bus.cu_dp_addr_o, bus.cu_tblock_size_o, bus.cu_tblock_idx_o, bus.cu_tgroup_id_o} == '0,
          "rst_cu_data", bus.cu_dp_addr_o, 0);
    for (int c = 0; c < NC; c++)
      check(credits[c*CW +: CW] == CW'(CR), "rst_credits", credits[c*CW +: CW], CR);
    check(stats == '0, "rst_stats", stats, 0);
  endtask

  initial begin : main
    logic [NC-1:0] held_vld;
    warp_req_t     held_dat;
    int            t, sum;
    int            exp_t [5];
    exp_t = '{0, 1, 2, 3, 0};
    bus.allocate_warp_i = 1'b0;
    bus.allocate_pc_i   = '0;
    bus.dp_addr_i       = '0;
    bus.tblock_size_i   = '0;
    bus.tblock_idx_i    = '0;
    bus.tgroup_id_i     = '0;
    repeat (3) tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();

    // Single request, all clusters ready: goes to cluster 0 and uses one of its slots
    send(0);
    wait_drain(0, "single_drain");
    check(credits[CW-1:0] == CW'(CR - 1), "single_credit0", credits[CW-1:0], CR - 1);

    // Back-to-back requests rotate 0,1,2,3 then wrap to 0
    for (int i = 0; i < 4; i++) send(0);
    wait_drain(0, "rr_drain");
    for (int i = 0; i < 5; i++)
      check(tgt_log[i] == exp_t[i], "rr_order", tgt_log[i], exp_t[i]);

    // Use every slot, then one more request must wait until a slot on cluster 2 frees up
    for (int i = 0; i < NC*CR - 5; i++) send($urandom_range(1));
    wait_drain(0, "fill_drain");
    send(0);
    repeat (10) tick();
    check(bus.warp_free_o == 1'b0, "full_warp_free", bus.warp_free_o, 0);
    check(bus.cu_valid_o == '0, "full_no_offer", bus.cu_valid_o, 0);
    inject_done = 4'b0100;
    wait_drain(0, "full_release_drain");
    check(tgt_log[tgt_log.size()-1] == 2, "full_release_target", tgt_log[tgt_log.size()-1], 2);
    done_en = 1'b1;
    wait_drain(1, "full_done_drain");

    // Target never ready for 20 cycles: offer and data must not move
    ready_pct = 0;
    send(0);
    t = 0;
    while (bus.cu_valid_o == '0 && t < 20) begin tick(); t++; end
    check(t < 20, "stall_offer_wait", t, 20);
    held_vld = bus.cu_valid_o;
    held_dat = {bus.cu_pc_o, bus.cu_dp_addr_o, bus.cu_tblock_size_o, bus.cu_tblock_idx_o, bus.cu_tgroup_id_o};
    repeat (20) tick();
    check(bus.cu_valid_o == held_vld, "stall_valid", bus.cu_valid_o, held_vld);
    check({bus.cu_pc_o, bus.cu_dp_addr_o, bus.cu_tblock_size_o, bus.cu_tblock_idx_o, bus.cu_tgroup_id_o} == held_dat,
          "stall_data", bus.cu_dp_addr_o, held_dat.dp_addr);
    ready_pct = 100;
    wait_drain(1, "stall_drain");

    // Completion with every slot already free is dropped
    done_en     = 1'b0;
    inject_done = 4'b0010;
    repeat (3) tick();
    check(credits[CW +: CW] == CW'(CR), "spurious_done_credit", credits[CW +: CW], CR);
    check(idle == 1'b1, "spurious_done_idle", idle, 1);
    done_en = 1'b1;

    // Random traffic with varying ready density
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) ready_pct = $urandom_range(30, 100);
      send($urandom_range(3));
    end
    wait_drain(1, "random_drain");

    // Reset in the middle of an offer drops it and refills every credit
    ready_pct = 0;
    send(0);
    t = 0;
    while (bus.cu_valid_o == '0 && t < 20) begin tick(); t++; end
    check(t < 20, "reset_offer_wait", t, 20);
    rst_n = 1'b0;
    tick();
    check_reset_state();
    tick();
    rst_n = 1'b1;
    tick();

    ready_pct = 70;
    for (int i = 0; i < 1000; i++) send($urandom_range(1));
    wait_drain(1, "bulk_drain");
    sum = 0;
    for (int c = 0; c < NC; c++) sum += m_st[c];
    check(sum == 1000, "model_dispatch_sum", sum, 1000);
`ifdef TBLOCK_DISTRIBUTOR_STATS_EN
    for (int c = 0; c < NC; c++)
      check(stats[c*32 +: 32] == 32'(m_st[c]), "stats_cluster", stats[c*32 +: 32], m_st[c]);
    sum = 0;
    for (int c = 0; c < NC; c++) sum += int'(stats[c*32 +: 32]);
    check(sum == 1000, "stats_sum", sum, 1000);
`else
    check(stats == '0, "stats_tied_off", stats, 0);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
